// File: rtl/serial_add_pkg.sv
// Shared constants for the time-shared serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_pkg;

  // FSM encoding, kept as plain 2-bit constants for legacy compatibility
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default geometry: a 4-bit adder slice reused 4 times gives 16-bit operands
  localparam int SA_N     = 4;
  localparam int SA_WORDS = 4;

  // Counter width for the slice index, at least one bit even for WORDS=1
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/ready request bus and result bus of the serial adder controller.
// Latency: n/a (wiring only).
// Backpressure: requester may only issue start while ready is high.
interface serial_add_ctrl_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         op_sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  // Front end issuing requests
  modport master (
    output start, op_sub, cin, a, b,
    input  ready, busy, done, sum, cout
  );

  // Controller serving requests
  modport slave (
    input  start, op_sub, cin, a, b,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_add_slice.sv
// Narrow ripple adder slice: {co, s} = x + y + ci.
// Latency: purely combinational.
// Backpressure: none.
module add_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  // Extend to N+1 bits so the carry-out falls out of the top bit
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract by reusing one N-bit slice, LSB slice first, one slice per clock.
// Latency: WORDS cycles from accept to the one-cycle done pulse.
// Backpressure: ready only in IDLE/DONE; start is ignored while busy.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int WORDS = SA_WORDS
) (
  input logic clk,
  input logic rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int W    = N * WORDS;
  localparam int IDXW = idx_width(WORDS);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  logic [1:0]      state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;

  logic [N-1:0]    slice_x;
  logic [N-1:0]    slice_y;
  logic [N-1:0]    slice_s;
  logic            slice_co;
  logic            accept;
  logic            last;

  // A request is taken only when idle or in the single DONE cycle
  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last   = (idx_q == IDX_LAST);

  assign slice_x = a_q[idx_q*N +: N];
  assign slice_y = b_q[idx_q*N +: N];

  add_slice #(.N(N)) u_slice (
    .x  (slice_x),
    .y  (slice_y),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // FSM: IDLE -> RUN on accept, RUN -> DONE after the last slice, DONE -> RUN or IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_q <= ST_RUN;
        ST_RUN:  if (last)   state_q <= ST_DONE;
        ST_DONE: state_q <= accept ? ST_RUN : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Operand capture at accept; subtract is folded into inverted B plus carry-in of 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.op_sub ? ~bus.b : bus.b;
    end
  end

  // Slice carry chain and index: seeded at accept, advanced once per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      carry_q <= bus.op_sub ? 1'b1 : bus.cin;
      idx_q   <= '0;
    end else if (state_q == ST_RUN) begin
      carry_q <= slice_co;
      idx_q   <= last ? '0 : idx_q + 1'b1;
    end
  end

  // Result write-back: cleared at accept, filled slice by slice, held after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      sum_q[idx_q*N +: N] <= slice_s;
      if (last) cout_q <= slice_co;
    end
  end

  assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with hand-computed expected results.
// Latency: checks done arrives WORDS cycles after accept.
// Backpressure: checks start is ignored while busy and accepted in DONE.
module tb_serial_add_ctrl;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;
  localparam int LIMIT = 20;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_add_ctrl_if #(.N(N), .WORDS(WORDS)) bus ();

  serial_add_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request at a negedge; the following posedge accepts it
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic ci);
    bus.a      = a;
    bus.b      = b;
    bus.op_sub = sub;
    bus.cin    = ci;
    bus.start  = 1'b1;
  endtask

  // Wait (bounded) for done, sampling on negedges; returns cycles waited and busy count
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
      if (bus.busy) nbusy++;
    end
  endtask

  // One complete operation from an idle controller, with latency and result checks
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic ci,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int cyc;
    int nbusy;
    @(negedge clk);
    issue(a, b, sub, ci);
    @(negedge clk);
    bus.start = 1'b0;
    nbusy = bus.busy ? 1 : 0;
    begin
      int c2;
      int b2;
      wait_done(c2, b2);
      cyc   = c2;
      nbusy = nbusy + b2;
    end
    chk({tag, "_lat"},  cyc, WORDS);
    chk({tag, "_busy"}, nbusy, WORDS);
    chk({tag, "_sum"},  bus.sum, exp_sum);
    chk({tag, "_cout"}, bus.cout, exp_cout);
    chk({tag, "_rdy"},  bus.ready, 1'b1);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 1'b0);
    chk({tag, "_hold"},  {bus.cout, bus.sum}, {exp_cout, exp_sum});
  endtask

  initial begin
    int cyc;
    int nbusy;
    int ndone;
    n_cmp = 0;
    n_err = 0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.cin = 1'b0;
    bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_busy",  bus.busy,  1'b0);
    chk("rst_done",  bus.done,  1'b0);
    chk("rst_sum",   bus.sum,   16'h0000);
    chk("rst_cout",  bus.cout,  1'b0);
    rst_n = 1'b1;

    run_op("add",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("cin",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1);
    run_op("cin2",   16'h00FF, 16'h0F01, 1'b0, 1'b1, 16'h1001, 1'b0);
    run_op("sub_ng", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub_ps", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    run_op("sub_hi", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1);

    // start pulsed with different operands during RUN must be ignored
    @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        ndone++;
        chk("ign_sum",  bus.sum,  16'h3333);
        chk("ign_cout", bus.cout, 1'b0);
      end
      @(negedge clk);
    end
    chk("ign_ndone", ndone, 1);

    // reset mid-RUN aborts at once and produces no done
    @(negedge clk);
    issue(16'h5A5A, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_busy",  bus.busy,  1'b0);
    chk("abort_done",  bus.done,  1'b0);
    chk("abort_sum",   bus.sum,   16'h0000);
    chk("abort_cout",  bus.cout,  1'b0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run_op("fresh", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);

    // back-to-back: start held through DONE, second op accepted there
    @(negedge clk);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 1'b0);
    wait_done(cyc, nbusy);
    chk("b2b_lat1",  cyc, WORDS + 1);
    chk("b2b_sum1",  bus.sum, 16'hFFFF);
    chk("b2b_cout1", bus.cout, 1'b0);
    issue(16'h1000, 16'h0001, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy2", bus.busy, 1'b1);
    begin
      int c2;
      wait_done(c2, nbusy);
      chk("b2b_gap", c2 + 1, WORDS + 1);
    end
    chk("b2b_sum2",  bus.sum, 16'h0FFF);
    chk("b2b_cout2", bus.cout, 1'b1);
    @(negedge clk);
    chk("b2b_idle", bus.ready && !bus.busy && !bus.done, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
